// File: rtl/me_best_match.sv
// Motion-estimation best-match selector: scans NPOS x NPOS candidate SADs and
// reports the motion vector of the smallest one (earliest candidate wins ties).
module me_best_match #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [5:0]       mv_x,
    output logic [5:0]       mv_y,
    output logic [SAD_W-1:0] best_sad
);
    localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int CW   = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPOS - 1);
    localparam logic [15:0]   HALF = 16'((NPOS - 1) / 2);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [SAD_W-1:0] best;
    logic [CW-1:0]    h_cnt, v_cnt, best_h, best_v;

    logic             upd, last;
    logic [SAD_W-1:0] nbest;
    logic [CW-1:0]    nh, nv;
    logic [15:0]      dx, dy;

    // Next-best view includes the current candidate, so the final sample is
    // folded into the result registered on the SCAN->DONE edge.
    always_comb begin
        upd   = sad < best;
        nbest = upd ? sad : best;
        nh    = upd ? h_cnt : best_h;
        nv    = upd ? v_cnt : best_v;
        last  = (h_cnt == LAST) && (v_cnt == LAST);
        dx    = 16'(nh) - HALF;
        dy    = 16'(nv) - HALF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            mv_valid <= 1'b0;
            mv_x     <= '0;
            mv_y     <= '0;
            best_sad <= '0;
            best     <= '1;
            h_cnt    <= '0;
            v_cnt    <= '0;
            best_h   <= '0;
            best_v   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        ready  <= 1'b0;
                        best   <= '1;
                        h_cnt  <= '0;
                        v_cnt  <= '0;
                        best_h <= '0;
                        best_v <= '0;
                    end
                end
                SCAN: begin
                    if (sad_valid) begin
                        best   <= nbest;
                        best_h <= nh;
                        best_v <= nv;
                        if (last) begin
                            state    <= DONE;
                            mv_valid <= 1'b1;
                            mv_x     <= dx[5:0];
                            mv_y     <= dy[5:0];
                            best_sad <= nbest;
                            h_cnt    <= '0;
                            v_cnt    <= '0;
                        end else if (v_cnt == LAST) begin
                            v_cnt <= '0;
                            h_cnt <= h_cnt + 1'b1;
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (mv_ready) begin
                        state    <= IDLE;
                        mv_valid <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    mv_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/me_best_match.md
ME_BEST_MATCH -- requirements
Module: me_best_match

Interface
REQ-001 Parameter MACRO_DIM, default 16, macroblock edge in pixels.
REQ-002 Parameter SEARCH_DIM, default 48, search-window edge in pixels; NPOS = SEARCH_DIM-MACRO_DIM+1 (33 by default) candidate offsets per axis.
REQ-003 Parameter SAD_W, default 16, SAD width in bits.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin search for a new macroblock; honoured only in IDLE.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 sad_valid  input  1  one candidate SAD present this cycle, from the ME datapath.
REQ-009 sad  input  SAD_W  candidate SAD, unsigned.
REQ-010 mv_valid  output  1  result available; high in DONE only.
REQ-011 mv_ready  input  1  downstream accepts result.
REQ-012 mv_x  output  6  signed horizontal vector, two's complement.
REQ-013 mv_y  output  6  signed vertical vector, two's complement.
REQ-014 best_sad  output  SAD_W  SAD of the selected candidate.

Function
REQ-015 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE on acceptance of candidate NPOS*NPOS (1089th); DONE->IDLE on mv_valid&&mv_ready; no other transitions.
REQ-016 On IDLE->SCAN: best register := all-ones, v_cnt := 0, h_cnt := 0, best_v := 0, best_h := 0.
REQ-017 In SCAN each cycle with sad_valid=1 accepts one candidate at (h_cnt, v_cnt); sad_valid=0 stalls with no state change.
REQ-018 Order: v_cnt fastest; v_cnt 0..NPOS-1, at NPOS-1 wraps to 0 and h_cnt increments; h_cnt final value NPOS-1.
REQ-019 Update best when sad < best (strict unsigned compare); ties keep earlier candidate.
REQ-020 Compare uses the registered best; the candidate accepted in the same cycle as a prior update compares against the updated value (one compare per cycle, no lost updates).
REQ-021 mv_x = best_h - (NPOS-1)/2, mv_y = best_v - (NPOS-1)/2; range -16..+16 at default parameters.
REQ-022 mv_x, mv_y, best_sad registered, updated on SCAN->DONE, stable throughout DONE and IDLE until next SCAN->DONE.
REQ-023 Latency: mv_valid rises the cycle after the final candidate is accepted.
REQ-024 mv_valid stays high in DONE until mv_ready; outputs shall not change while mv_valid=1 and mv_ready=0.
REQ-025 start outside IDLE ignored; sad_valid outside SCAN ignored.
REQ-026 start and mv_ready in same DONE cycle: transition to IDLE only; start not captured.
REQ-027 Candidate with sad = all-ones when best = all-ones: not selected; if all 1089 SADs are all-ones, result is mv=(-16,-16), best_sad=all-ones.

Reset
REQ-028 rst_n=0 sampled at clk edge forces IDLE, ready=1, mv_valid=0, mv_x=0, mv_y=0, best_sad=0, counters 0; applies mid-SCAN or mid-DONE, discarding partial search.

Verification
REQ-029 Reset, then start; 1089 SADs with only (h=20,v=5) = 100, others 500 -> mv_valid one cycle after last, mv_x=+4, mv_y=-11, best_sad=100.
REQ-030 Ties: SAD 50 at (3,7) and (10,2), others 900 -> mv_x=-13, mv_y=-9, best_sad=50 (earlier wins).
REQ-031 Random sad_valid gaps (~50% duty) with same data as REQ-029 -> identical result; mv_valid only after 1089th accepted sample.
REQ-032 Hold mv_ready=0 for 10 cycles in DONE, toggle start -> mv_valid and outputs stable, ready=0; then mv_ready=1 -> IDLE next cycle, ready=1.
REQ-033 rst_n low for one cycle after 500 candidates -> IDLE, all outputs at reset values; new start plus full 1089 stream gives correct result.
REQ-034 All SADs = 0 -> mv_x=-16, mv_y=-16, best_sad=0; extra sad_valid pulses in IDLE/DONE -> no effect.
